// File: rtl/lr_loss_acc_if.sv
// Sample-in / batch-result-out handshake bundle for the loss accumulator.
// Master drives samples and result-ready; slave is the accumulator.
interface lr_loss_acc_if;
    logic [3:0]  y_pred;
    logic [3:0]  y_true;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] loss_sum;
    logic [3:0]  max_abs_err;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output y_pred, y_true, in_valid, out_ready,
        input  in_ready, loss_sum, max_abs_err, out_valid
    );

    modport slave (
        input  y_pred, y_true, in_valid, out_ready,
        output in_ready, loss_sum, max_abs_err, out_valid
    );
endinterface

// File: rtl/lr_loss_acc.sv
// Batch sum-of-squared-error and max-abs-error accumulator for the
// linear regression stage; two-stage datapath plus ACC/DRAIN/HOLD FSM.
module lr_loss_acc #(
    parameter int unsigned BATCH = 8
) (
    input logic         clk,
    input logic         rst,
    lr_loss_acc_if.slave bus
);
    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(BATCH - 1);

    state_t state, state_nx;

    logic [7:0]  cnt;
    logic [15:0] acc;
    logic [3:0]  max;
    logic        s1_valid;
    logic [7:0]  s1_sq;
    logic [3:0]  s1_abs;

    logic        in_ready;
    logic        out_valid;
    logic        accept;
    logic        release_res;

    logic signed [4:0] err;
    logic        [4:0] err_mag;
    logic        [3:0] abs_err;
    logic        [7:0] sq;

    // |-15| = 15 still fits the 5-bit signed range, so negation is safe
    assign err     = $signed({1'b0, bus.y_pred}) - $signed({1'b0, bus.y_true});
    assign err_mag = err[4] ? 5'(-err) : 5'(err);
    assign abs_err = err_mag[3:0];
    assign sq      = {4'd0, abs_err} * {4'd0, abs_err};

    assign accept      = bus.in_valid && in_ready;
    assign release_res = (state == HOLD) && bus.out_ready;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACC: begin
                in_ready = 1'b1;
                if (bus.in_valid && cnt == LAST)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (bus.out_ready)
                    state_nx = ACC;
            end
            default: begin
                state_nx = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            cnt      <= 8'd0;
            acc      <= 16'd0;
            max      <= 4'd0;
            s1_valid <= 1'b0;
            s1_sq    <= 8'd0;
            s1_abs   <= 4'd0;
        end else begin
            state    <= state_nx;
            s1_valid <= accept;
            if (accept) begin
                s1_sq  <= sq;
                s1_abs <= abs_err;
                cnt    <= cnt + 8'd1;
            end
            // s1_valid is never set in HOLD, so release and absorb cannot collide
            if (release_res) begin
                acc <= 16'd0;
                max <= 4'd0;
                cnt <= 8'd0;
            end else if (s1_valid) begin
                acc <= acc + {8'd0, s1_sq};
                if (s1_abs > max)
                    max <= s1_abs;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.loss_sum    = acc;
    assign bus.max_abs_err = max;
endmodule

// File: tb/tb_lr_loss_acc.sv
// Scoreboard bench for lr_loss_acc: three instances (BATCH 4, 1, 255)
// driven with directed vectors; a monitor checks every released result.
module tb_lr_loss_acc;
    logic        clk;
    logic [2:0]  rst;
    logic [3:0]  yp [3];
    logic [3:0]  yt [3];
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  irdy;
    logic [2:0]  ovld;
    logic [15:0] loss [3];
    logic [3:0]  mx [3];

    int nvec  = 0;
    int nfail = 0;

    // {instance, loss_sum, max_abs_err}
    logic [21:0] expq [$];

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int unsigned B = (k == 0) ? 4 : (k == 1) ? 1 : 255;
        lr_loss_acc_if u_if ();
        assign u_if.y_pred    = yp[k];
        assign u_if.y_true    = yt[k];
        assign u_if.in_valid  = iv[k];
        assign u_if.out_ready = ordy[k];
        assign irdy[k]        = u_if.in_ready;
        assign ovld[k]        = u_if.out_valid;
        assign loss[k]        = u_if.loss_sum;
        assign mx[k]          = u_if.max_abs_err;
        lr_loss_acc #(.BATCH(B)) u_dut (
            .clk (clk),
            .rst (rst[k]),
            .bus (u_if.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(int k, int s, int m);
        expq.push_back({2'(k), 16'(s), 4'(m)});
    endtask

    task automatic send(int k, logic [3:0] p, logic [3:0] t);
        int n;
        yp[k] = p;
        yt[k] = t;
        iv[k] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!irdy[k] && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 1000) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ovld[k] && ordy[k]) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_result inst %0d: got %0d/%0d want none",
                             k, loss[k], mx[k]);
                end else begin
                    logic [21:0] e;
                    e = expq.pop_front();
                    chk("result_inst", k, int'(e[21:20]));
                    chk("loss_sum", int'(loss[k]), int'(e[19:4]));
                    chk("max_abs_err", int'(mx[k]), int'(e[3:0]));
                end
            end
        end
    end

    initial begin
        logic [3:0] pp [4];
        logic [3:0] tt [4];
        int gp [4];
        pp = '{4'd5, 4'd2, 4'd9, 4'd15};
        tt = '{4'd3, 4'd7, 4'd9, 4'd0};
        gp = '{1, 3, 0, 2};
        rst  = 3'b111;
        iv   = 3'b000;
        ordy = 3'b111;
        for (int k = 0; k < 3; k++) begin
            yp[k] = 4'd0;
            yt[k] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", int'(irdy[k]), 1);
            chk("rst_out_valid", int'(ovld[k]), 0);
            chk("rst_loss_sum", int'(loss[k]), 0);
            chk("rst_max_abs_err", int'(mx[k]), 0);
        end
        @(posedge clk);
        #1;

        // back-to-back batch with latency check
        push(0, 254, 15);
        for (int i = 0; i < 4; i++) send(0, pp[i], tt[i]);
        @(negedge clk);
        chk("lat_drain_out_valid", int'(ovld[0]), 0);
        chk("lat_drain_in_ready", int'(irdy[0]), 0);
        @(negedge clk);
        chk("lat_hold_out_valid", int'(ovld[0]), 1);
        wait_drain();

        // same batch with input gaps
        push(0, 254, 15);
        for (int i = 0; i < 4; i++) begin
            send(0, pp[i], tt[i]);
            idle(gp[i]);
        end
        wait_drain();

        // stall in HOLD while in_valid keeps offering (15,0)
        ordy[0] = 1'b0;
        push(0, 254, 15);
        for (int i = 0; i < 4; i++) send(0, pp[i], tt[i]);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!ovld[0] && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("hold_reached", int'(ovld[0]), 1);
        end
        yp[0] = 4'd15;
        yt[0] = 4'd0;
        iv[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_loss_sum", int'(loss[0]), 254);
            chk("stall_max_abs_err", int'(mx[0]), 15);
            chk("stall_in_ready", int'(irdy[0]), 0);
            chk("stall_out_valid", int'(ovld[0]), 1);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        iv[0]   = 1'b0;
        push(0, 4, 1);
        for (int i = 0; i < 4; i++) send(0, 4'd1, 4'd0);
        wait_drain();

        // reset mid-batch discards the partial result
        send(0, 4'd15, 4'd0);
        send(0, 4'd15, 4'd0);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", int'(irdy[0]), 1);
        chk("midrst_out_valid", int'(ovld[0]), 0);
        chk("midrst_loss_sum", int'(loss[0]), 0);
        chk("midrst_max_abs_err", int'(mx[0]), 0);
        push(0, 4, 1);
        for (int i = 0; i < 4; i++) send(0, 4'd1, 4'd0);
        wait_drain();

        // BATCH=1
        push(1, 225, 15);
        send(1, 4'd0, 4'd15);
        push(1, 0, 0);
        send(1, 4'd7, 4'd7);
        wait_drain();

        // BATCH=255 at full error, no wrap
        push(2, 57375, 15);
        repeat (255) send(2, 4'd15, 4'd0);
        wait_drain();

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/lr_loss_acc.md
LR_LOSS_ACC -- requirements
Module: lr_loss_acc

Interface
REQ-001 Parameter: BATCH, default 8, samples per loss batch; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 y_pred  input  4  unsigned prediction from the linear regression stage.
REQ-005 y_true  input  4  unsigned target value for the same sample.
REQ-006 in_valid  input  1  y_pred/y_true pair valid this cycle.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 loss_sum  output  16  sum of squared errors over the completed batch.
REQ-009 max_abs_err  output  4  largest |y_pred - y_true| in the completed batch.
REQ-010 out_valid  output  1  loss_sum/max_abs_err hold a completed batch result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-012 Sample accepted when in_valid && in_ready at a rising edge; otherwise inputs are ignored.
REQ-013 Error = y_pred - y_true as 5-bit signed; abs_err 4-bit unsigned (0..15); sq = abs_err*abs_err, 8-bit unsigned (0..225).
REQ-014 Stage 1: on acceptance, register s1_sq, s1_abs and s1_valid=1; s1_valid=0 in any cycle without acceptance.
REQ-015 Stage 2: when s1_valid=1, acc <= acc + s1_sq (16-bit, no overflow possible for BATCH<=255) and max <= max(max, s1_abs).
REQ-016 Sample counter 8-bit counts accepted samples in the current batch.
REQ-017 FSM states: ACC, DRAIN, HOLD; reset state ACC.
REQ-018 ACC: in_ready=1, out_valid=0; on acceptance with counter == BATCH-1 go to DRAIN, else stay, counter+1.
REQ-019 DRAIN: in_ready=0, out_valid=0; exactly one cycle, absorbs final stage-1 sample; next state HOLD.
REQ-020 HOLD: in_ready=0, out_valid=1; loss_sum=acc, max_abs_err=max, stable until handshake.
REQ-021 HOLD with out_ready=1 at an edge: clear acc, max, counter to 0, go to ACC; in_ready=1 the following cycle.
REQ-022 out_ready ignored outside HOLD; in_valid ignored in DRAIN and HOLD (sample not consumed, not counted).
REQ-023 Latency: out_valid rises 2 cycles after the edge accepting the last batch sample.
REQ-024 BATCH=1: every accepted sample goes ACC->DRAIN->HOLD directly.
REQ-025 Back-to-back acceptance in ACC every cycle is supported; max throughput BATCH samples per BATCH+2+handshake cycles.
REQ-026 loss_sum and max_abs_err outside HOLD show the running acc/max (informational only; consumer uses them only with out_valid=1).

Reset
REQ-027 rst=1 at an edge forces state ACC, counter=0, acc=0, max=0, s1_valid=0, s1_sq=0, s1_abs=0, regardless of state.
REQ-028 Output values after reset: in_ready=1, out_valid=0, loss_sum=0, max_abs_err=0.
REQ-029 Reset mid-batch or in HOLD discards partial/pending result; no out_valid pulse produced for it.

Verification
REQ-030 BATCH=4, pairs (5,3),(2,7),(9,9),(15,0) back-to-back -> out_valid 2 cycles after 4th accept, loss_sum=254, max_abs_err=15.
REQ-031 BATCH=4, same pairs with in_valid gaps of 0-3 cycles -> identical result 254/15; counter counts only accepted samples.
REQ-032 HOLD with out_ready=0 for 5 cycles while in_valid=1 with (15,0) -> outputs stay 254/15, in_ready=0, no sample absorbed; next batch after out_ready starts from 0.
REQ-033 BATCH=1, pair (0,15) -> loss_sum=225, max_abs_err=15; then (7,7) -> loss_sum=0, max_abs_err=0.
REQ-034 BATCH=255, all pairs (15,0) -> loss_sum=57375, max_abs_err=15, no wrap.
REQ-035 rst=1 for one cycle after 2 of 4 samples -> next 4 samples (1,0) yield loss_sum=4, max_abs_err=1.
